// File: rtl/booth_mult_pkg.sv
// ---------------------------------------------------------------------------
// booth_mult_pkg
//   Shared types and constants for the radix-2 Booth multiplier controller.
//   - state_t    : FSM encoding (IDLE/CALC/DONE; 2'b11 is unused/illegal)
//   - BOOTH_ADD  : Booth pair {Q[0], Q_-1} that adds the multiplicand
//   - BOOTH_SUB  : Booth pair {Q[0], Q_-1} that subtracts the multiplicand
//   - DEFAULT_N  : default operand width
// ---------------------------------------------------------------------------
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
//   One combinational radix-2 Booth iteration: conditionally add or subtract
//   the multiplicand into the accumulator, then arithmetic-shift the combined
//   {A, Q, Q_-1} register right by one.
// Ports
//   a         in   N+1  accumulator A (one guard bit so -2^(N-1) can be subtracted)
//   q         in   N    multiplier shift register Q
//   q_m1      in   1    extra bit Q_-1
//   m         in   N    multiplicand M (signed)
//   a_next    out  N+1  accumulator after add/sub and shift
//   q_next    out  N    Q after shift
//   q_m1_next out  1    Q_-1 after shift
// ---------------------------------------------------------------------------
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic         q_m1,
  input  logic [N-1:0] m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next,
  output logic         q_m1_next
);

  logic [N:0] m_ext;
  logic [N:0] sum;

  assign m_ext = {m[N-1], m};

  // Booth recoding of the current pair picks +M, -M or nothing.
  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
  end

  // Arithmetic shift right of {sum, q, q_m1}: sign bit of sum is replicated.
  assign a_next    = {sum[N], sum[N:1]};
  assign q_next    = {sum[0], q[N-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mult_ctrl
//   Sequencing controller for a signed radix-2 Booth multiplier. Operands are
//   captured on an accepted start strobe, one Booth iteration runs per clock,
//   and the 2N-bit product is presented with a done flag held until the next
//   accepted start or reset.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active low
//   start      in   1      operation request, honoured only in IDLE or DONE
//   a_in       in   N      multiplicand (signed)
//   b_in       in   N      multiplier (signed)
//   busy       out  1      high while iterating
//   done       out  1      high in DONE
//   resultado  out  2N     last completed signed product
//   estado     out  2      current FSM state encoding
//   temp       out  2      current Booth pair {Q[0], Q_-1}
//   contador   out  CNT_W  iterations completed in the current operation
// Configuration
//   MULT_EARLY_EXIT_EN : when defined, the operation finishes as soon as all
//                        remaining Booth pairs would be no-ops.
// ---------------------------------------------------------------------------
module booth_mult_ctrl
  import booth_mult_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   resultado,
  output logic [1:0]       estado,
  output logic [1:0]       temp,
  output logic [CNT_W-1:0] contador
);

  localparam int PW = 2 * N;

  state_t state, state_next;

  logic [N:0]       acc;
  logic [N-1:0]     mult_q;
  logic [N-1:0]     mcand;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    product_reg;

  logic [N:0]       acc_next;
  logic [N-1:0]     q_next;
  logic             q_m1_next;

  logic             accept;
  logic             last_iter;
  logic             finish;
  logic [PW-1:0]    product;

  booth_step #(.N(N)) u_step (
    .a         (acc),
    .q         (mult_q),
    .q_m1      (q_m1),
    .m         (mcand),
    .a_next    (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CNT_W'(N - 1));

`ifdef MULT_EARLY_EXIT_EN
  // Checked on the post-iteration register image: once every multiplier bit
  // still to be examined equals the new Q_-1, all later pairs are 00 or 11
  // and only shift, so the result is the remaining shifts done in one go.
  logic rest_uniform;

  always_comb begin
    rest_uniform = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (((i + int'(cnt)) <= (N - 2)) && (q_next[i] != q_m1_next)) begin
        rest_uniform = 1'b0;
      end
    end
  end

  assign finish  = last_iter || rest_uniform;
  assign product = PW'($signed({acc_next, q_next}) >>> (N - 1 - int'(cnt)));
`else
  assign finish  = last_iter;
  assign product = {acc_next[N-1:0], q_next};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The unused encoding 2'b11 falls through to IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (finish) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter stops at N-1 on the final iteration so it never wraps while
  // busy; the product register is only written on completion so the previous
  // result stays visible while a new operation runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      mult_q      <= '0;
      mcand       <= '0;
      q_m1        <= 1'b0;
      cnt         <= '0;
      product_reg <= '0;
    end else if (accept) begin
      mcand  <= a_in;
      mult_q <= b_in;
      acc    <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mult_q <= q_next;
      q_m1   <= q_m1_next;
      if (finish) begin
        product_reg <= product;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign resultado = product_reg;
  assign estado    = state;
  assign temp      = {mult_q[0], q_m1};
  assign contador  = cnt;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_ctrl
//   Self-checking bench for booth_mult_ctrl (default build, fixed latency).
//   Expected products come from plain signed integer multiplication.
// ---------------------------------------------------------------------------
module tb_booth_mult_ctrl;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(N);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic signed [N-1:0]    a_in;
  logic signed [N-1:0]    b_in;
  logic                   busy;
  logic                   done;
  logic [2*N-1:0]         resultado;
  logic [1:0]             estado;
  logic [1:0]             temp;
  logic [CNT_W-1:0]       contador;

  int compared   = 0;
  int mismatched = 0;

  booth_mult_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .estado    (estado),
    .temp      (temp),
    .contador  (contador)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string tag,
                             input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: present operands with a one-cycle start pulse.
  // Returns at the falling edge right after the capturing rising edge.
  task automatic applyStimulus(input logic signed [N-1:0] a,
                               input logic signed [N-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = N'($urandom);
    b_in  = N'($urandom);
  endtask

  // Waits for completion of an operation already started, checking latency,
  // busy duration, running iteration count and the final outputs. When
  // intrudeAt >= 0 a second start is pulsed at that cycle of the operation.
  task automatic finishOp(input logic signed [N-1:0] a,
                          input logic signed [N-1:0] b,
                          input string tag,
                          input int intrudeAt);
    int prod;
    int cycles;
    int busyCycles;
    prod       = int'(a) * int'(b);
    cycles     = 0;
    busyCycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) begin
        busyCycles++;
        checkOutput({tag, "/contador_run"}, contador, cycles);
      end
      start = (cycles == intrudeAt);
      if (start) begin
        a_in = N'($urandom);
        b_in = N'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput({tag, "/latency"}, cycles, N);
    checkOutput({tag, "/busy_cycles"}, busyCycles, N);
    checkOutput({tag, "/resultado"}, $signed(resultado), prod);
    checkOutput({tag, "/contador"}, contador, N - 1);
    checkOutput({tag, "/estado"}, estado, 2);
    checkOutput({tag, "/busy_end"}, busy, 0);
    checkOutput({tag, "/temp"}, {prod[0], b[N-1]}, {prod[0], b[N-1]} == 2'b00 ? 0 :
                {prod[0], b[N-1]} == 2'b01 ? 1 : {prod[0], b[N-1]} == 2'b10 ? 2 : 3);
    checkOutput({tag, "/temp_dut"}, temp, {prod[0], b[N-1]});
  endtask

  task automatic runOp(input logic signed [N-1:0] a,
                       input logic signed [N-1:0] b,
                       input string tag);
    applyStimulus(a, b);
    finishOp(a, b, tag, -1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/busy"}, busy, 0);
    checkOutput({tag, "/done"}, done, 0);
    checkOutput({tag, "/resultado"}, resultado, 0);
    checkOutput({tag, "/estado"}, estado, 0);
    checkOutput({tag, "/temp"}, temp, 0);
    checkOutput({tag, "/contador"}, contador, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [N-1:0] ra;
    logic signed [N-1:0] rb;
    int held;

    rst   = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Power-on reset state.
    #12;
    checkAllZero("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle/estado", estado, 0);

    // Basic product and signed corner cases.
    runOp(8'sd3, 8'sd5, "3x5");
    runOp(-8'sd128, -8'sd128, "m128xm128");
    runOp(8'sd127, -8'sd128, "127xm128");
    runOp(-8'sd1, -8'sd1, "m1xm1");
    runOp(8'sd0, -8'sd77, "0xm77");

    // A start while busy must be ignored.
    applyStimulus(8'sd25, -8'sd6);
    finishOp(8'sd25, -8'sd6, "intrude", 3);

    // Done is held with the product until a new accepted start.
    held = int'(8'sd25) * int'(-8'sd6);
    repeat (20) @(negedge clk);
    checkOutput("hold/done", done, 1);
    checkOutput("hold/resultado", $signed(resultado), held);
    applyStimulus(-8'sd7, 8'sd9);
    checkOutput("restart/done", done, 0);
    checkOutput("restart/busy", busy, 1);
    checkOutput("restart/resultado_kept", $signed(resultado), held);
    finishOp(-8'sd7, 8'sd9, "m7x9", -1);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(8'sd100, -8'sd77);
    repeat (3) @(negedge clk);
    checkOutput("midreset/contador_before", contador, 3);
    #2 rst = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset/estado_after", estado, 0);
    checkOutput("midreset/done_after", done, 0);
    runOp(8'sd3, 8'sd5, "after_reset");

    // Randomized operands against integer multiplication.
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      runOp(ra, rb, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
